// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above rr_ptr, with wrap.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any,
  output logic [ID_W-1:0]  w
);

  always_comb begin
    any = |req_valid;
    w   = '0;
    // Walk from the farthest offset down so the nearest hit is the one kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'((int'(rr_ptr) + k) % N_REQ)]) begin
        w = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting N_REQ byte requesters access to one uart_sender,
// with a send timeout and an enforced idle gap between frames.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 16,
  parameter int ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ack,
  input  logic                 tx_done,
  output logic                 send_enable,
  output logic [7:0]           data_to_send,
  output logic [ID_W-1:0]      owner_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt;
  logic [N_REQ-1:0]  ack_nxt;
  logic              send_nxt, to_nxt;
  logic [7:0]        data_nxt;
  logic [ID_W-1:0]   owner_nxt;
  logic              pick_any;
  logic [ID_W-1:0]   pick_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .w         (pick_w)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      req_ack      <= '0;
      send_enable  <= 1'b0;
      data_to_send <= 8'h00;
      owner_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rr_ptr       <= rr_nxt;
      req_ack      <= ack_nxt;
      send_enable  <= send_nxt;
      data_to_send <= data_nxt;
      owner_id     <= owner_nxt;
      timeout_err  <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    ack_nxt   = '0;
    send_nxt  = send_enable;
    data_nxt  = data_to_send;
    owner_nxt = owner_id;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_any) begin
          ack_nxt   = N_REQ'(1) << pick_w;
          data_nxt  = req_data[int'(pick_w)*8 +: 8];
          owner_nxt = pick_w;
          send_nxt  = 1'b1;
          rr_nxt    = (pick_w == ID_W'(N_REQ - 1)) ? '0 : pick_w + ID_W'(1);
          state_nxt = SEND;
        end
      end
      SEND: begin
        // tx_done wins over a simultaneous timeout.
        if (tx_done || cnt == TO_LAST) begin
          send_nxt  = 1'b0;
          to_nxt    = ~tx_done;
          cnt_nxt   = '0;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        send_nxt  = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int TMO  = 50;
  localparam int GAPC = 16;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic          tx_done;
  logic          send_enable;
  logic [7:0]    data_to_send;
  logic [1:0]    owner_id;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .N_REQ          (NR),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAPC)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .tx_done      (tx_done),
    .send_enable  (send_enable),
    .data_to_send (data_to_send),
    .owner_id     (owner_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 sending (k = send cycle number), 2 gap (left = cycles remaining).
  int         m_mode = 0, m_k = 0, m_left = 0, m_ptr = 0, m_owner = 0;
  logic       m_send = 1'b0, m_to = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_ack = 4'h0;
  int         w_tmp;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_k <= 0; m_left <= 0; m_ptr <= 0; m_owner <= 0;
      m_send <= 1'b0; m_to <= 1'b0; m_data <= 8'h00; m_ack <= 4'h0;
    end else begin
      m_ack <= 4'h0;
      m_to  <= 1'b0;
      case (m_mode)
        0: if (req_valid != 0) begin
          w_tmp = pick(req_valid, m_ptr);
          m_ack   <= 4'(1 << w_tmp);
          m_data  <= req_data[w_tmp*8 +: 8];
          m_owner <= w_tmp;
          m_send  <= 1'b1;
          m_mode  <= 1;
          m_k     <= 1;
          m_ptr   <= (w_tmp + 1) % NR;
        end
        1: if (tx_done || m_k == TMO) begin
          m_send <= 1'b0;
          m_to   <= !tx_done;
          if (GAPC == 0) m_mode <= 0;
          else begin m_mode <= 2; m_left <= GAPC; end
        end else m_k <= m_k + 1;
        default: if (m_left <= 1) m_mode <= 0; else m_left <= m_left - 1;
      endcase
    end
  end

  always @(negedge sys_clk) begin
    chk("cycle {send,data,owner,busy,ack,terr}",
        int'({send_enable, data_to_send, owner_id, busy, req_ack, timeout_err}),
        int'({m_send, m_data, 2'(m_owner), (m_mode != 0), m_ack, m_to}));
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wait_ack(input bit clr, output int who, output int waited, output int ackv);
    who = -1; waited = 0; ackv = 0;
    while (waited < 100) begin
      tick();
      waited++;
      if (req_ack != 0) begin
        ackv = int'(req_ack);
        for (int k = 0; k < NR; k++) if (req_ack[k]) who = k;
        if (clr) req_valid = req_valid & ~req_ack;
        break;
      end
    end
    if (who < 0) chk("ack_wait_expired", 0, 1);
  endtask

  task automatic frame(input int done_at, input int spur_gap, output int sl, output int tn, output int gl);
    sl = 0; tn = 0; gl = 0;
    while (send_enable && sl < 400) begin
      sl++;
      tx_done = (sl == done_at);
      tick();
      tx_done = 1'b0;
      if (timeout_err) tn++;
    end
    while (busy && gl < 400) begin
      gl++;
      tx_done = (gl == spur_gap);
      tick();
      tx_done = 1'b0;
    end
  endtask

  int who, waited, ackv, sl, tn, gl;
  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req_valid = '0; tx_done = 1'b0;
    req_data = {8'hC3, 8'hB2, 8'hA1, 8'h55};
    repeat (3) tick();
    chk("rst_send", int'(send_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(data_to_send), 0);
    reset = 1'b0;

    // spurious tx_done while idle
    tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    chk("idle_spurious_busy", int'(busy), 0);

    // single requester
    req_valid = 4'b0001;
    wait_ack(1, who, waited, ackv);
    chk("single_ack", ackv, 1);
    chk("single_wait", waited, 1);
    chk("single_data", int'(data_to_send), 8'h55);
    frame(5, 0, sl, tn, gl);
    chk("single_send_len", sl, 5);
    chk("single_gap_len", gl, 16);
    chk("single_terr", tn, 0);
    chk("single_busy_after", int'(busy), 0);

    // fairness from a fresh pointer
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(0, who, waited, ackv);
      chk("fair_who", who, ord[g]);
      chk("fair_owner", int'(owner_id), ord[g]);
      chk("fair_wait", waited, 1);
      if (g == 4) req_valid = '0;
      frame(10, 0, sl, tn, gl);
      chk("fair_send_len", sl, 10);
    end

    // timeout, then next requester after the gap
    req_valid = 4'b0110;
    wait_ack(1, who, waited, ackv);
    chk("to_who", who, 1);
    frame(0, 0, sl, tn, gl);
    chk("to_send_len", sl, 50);
    chk("to_pulses", tn, 1);
    chk("to_gap_len", gl, 16);
    wait_ack(1, who, waited, ackv);
    chk("to_next_who", who, 2);
    chk("to_next_wait", waited, 1);
    chk("to_next_data", int'(data_to_send), 8'hB2);
    frame(3, 0, sl, tn, gl);

    // tx_done on the last allowed cycle
    req_valid = 4'b0001;
    wait_ack(1, who, waited, ackv);
    chk("edge_who", who, 0);
    frame(50, 0, sl, tn, gl);
    chk("edge_send_len", sl, 50);
    chk("edge_terr", tn, 0);
    chk("edge_gap_len", gl, 16);

    // spurious tx_done in the gap
    req_valid = 4'b0100;
    wait_ack(1, who, waited, ackv);
    chk("gapsp_who", who, 2);
    frame(4, 6, sl, tn, gl);
    chk("gapsp_send_len", sl, 4);
    chk("gapsp_gap_len", gl, 16);

    // reset in the fifth send cycle
    req_valid = 4'b0100;
    wait_ack(1, who, waited, ackv);
    chk("rstmid_who", who, 2);
    repeat (4) tick();
    chk("rstmid_send_before", int'(send_enable), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_send", int'(send_enable), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_owner", int'(owner_id), 0);
    chk("rstmid_data", int'(data_to_send), 0);
    chk("rstmid_ack_terr", int'({req_ack, timeout_err}), 0);
    req_valid = 4'b1010;
    tick(); tick();
    reset = 1'b0;
    wait_ack(1, who, waited, ackv);
    req_valid = '0;
    chk("rstmid_next_who", who, 1);
    chk("rstmid_next_wait", waited, 1);
    frame(3, 0, sl, tn, gl);
    chk("rstmid_gap_len", gl, 16);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
